// File: rtl/msg_sequencer.sv
// msg_sequencer: walks the character ROM and streams its message over a valid/ready handshake.
module msg_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int MSG_LEN = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              repeat_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   char_count
);
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MSG_LEN - 1);
  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] out_n;
  logic              valid_n, done_n, hs;
  logic [ADDR_W:0]   count_n, count_inc;
  assign hs        = char_valid && char_ready;
  assign count_inc = char_count + (ADDR_W+1)'(1);
  assign busy      = state != IDLE;
  always_comb begin
    state_n = state;
    addr_n  = rom_addr;
    out_n   = char_out;
    valid_n = char_valid;
    count_n = char_count;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          count_n = '0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        out_n   = rom_data;
        valid_n = rom_data != '0;
        done_n  = rom_data == '0;
        state_n = rom_data == '0 ? DONE : SEND;
      end
      SEND: begin
        if (hs) begin
          valid_n = 1'b0;
          count_n = (rom_addr == LAST && repeat_en) ? '0 : count_inc;
          done_n  = rom_addr == LAST;
          addr_n  = rom_addr == LAST ? '0 : rom_addr + 1'b1;
          state_n = (rom_addr == LAST && !repeat_en) ? DONE : FETCH;
        end
      end
      DONE: begin
        addr_n  = '0;
        state_n = IDLE;
      end
    endcase
    // abort wins over everything, but a handshake in the same cycle still counts
    if (abort) begin
      state_n = IDLE;
      addr_n  = '0;
      valid_n = 1'b0;
      done_n  = 1'b0;
      count_n = hs ? count_inc : char_count;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr   <= '0;
      char_out   <= '0;
      char_valid <= 1'b0;
      done       <= 1'b0;
      char_count <= '0;
    end else begin
      state      <= state_n;
      rom_addr   <= addr_n;
      char_out   <= out_n;
      char_valid <= valid_n;
      done       <= done_n;
      char_count <= count_n;
    end
  end
endmodule

// File: tb/tb_msg_sequencer.sv
// tb_msg_sequencer: directed and randomized checks of msg_sequencer against a message-stream model.
module tb_msg_sequencer;
  logic clk = 0, rst = 1, start = 0, abort = 0, repeat_en = 0, char_ready = 0, sel = 0;
  logic [7:0] rom [16];
  logic [3:0] a10, a16, a;
  logic [7:0] rd10, rd16, o10, o16, o;
  logic v10, v16, v, b10, b16, b, d10, d16, d;
  logic [4:0] c10, c16, cnt;
  int total = 0, bad = 0;
  logic [7:0] got[$], exp_q[$];
  int hs_cyc[$], done_cyc[$];
  int end_cyc, cnt_at_done, max_addr;

  always #5 clk = ~clk;
  assign rd10 = rom[a10];
  assign rd16 = rom[a16];
  assign a   = sel ? a16 : a10;
  assign o   = sel ? o16 : o10;
  assign v   = sel ? v16 : v10;
  assign b   = sel ? b16 : b10;
  assign d   = sel ? d16 : d10;
  assign cnt = sel ? c16 : c10;

  msg_sequencer #(.ADDR_W(4), .DATA_W(8), .MSG_LEN(10)) u10 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .repeat_en(repeat_en),
    .rom_addr(a10), .rom_data(rd10), .char_out(o10), .char_valid(v10),
    .char_ready(char_ready), .busy(b10), .done(d10), .char_count(c10));
  msg_sequencer #(.ADDR_W(4), .DATA_W(8), .MSG_LEN(16)) u16 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .repeat_en(repeat_en),
    .rom_addr(a16), .rom_data(rd16), .char_out(o16), .char_valid(v16),
    .char_ready(char_ready), .busy(b16), .done(d16), .char_count(c16));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected stream: message bytes in address order, wrapping every len, cut at the first NUL
  task automatic build(input int len, input int limit);
    exp_q.delete();
    for (int i = 0; exp_q.size() < limit; i++) begin
      if (rom[i % len] == 8'h00) break;
      exp_q.push_back(rom[i % len]);
    end
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk({tag, "_byte"}, got[i], exp_q[i]);
  endtask

  function automatic int first_done(input int k);
    return done_cyc.size() > k ? done_cyc[k] : -1;
  endfunction

  // mode 0: ready always, 1: three wait cycles per character, 2: random ready
  task automatic run(input int mode, input int rep_drop, input int abort_at, input int start_at, input int maxc);
    int cyc, waited;
    logic pv, phs;
    logic [7:0] po;
    bit aborted;
    got.delete(); hs_cyc.delete(); done_cyc.delete();
    cyc = 1; waited = 0; pv = 0; phs = 0; po = 0; aborted = 0;
    max_addr = 0; end_cyc = -1; cnt_at_done = -1;
    repeat_en = rep_drop > 0;
    start = 1;
    tick;
    start = 0;
    while (cyc < maxc) begin
      repeat_en = got.size() < rep_drop;
      abort = 0;
      if (abort_at >= 0 && got.size() == abort_at && !aborted) begin
        abort = 1;
        aborted = 1;
      end
      start = got.size() == start_at;
      char_ready = mode == 0 ? 1'b1 : mode == 1 ? !(v && waited < 3) : 1'($urandom_range(0, 1));
      if (mode == 1 && v && waited < 3) waited++;
      if (pv && !phs) chk("stable", o, po);
      phs = v && char_ready;
      pv = v;
      po = o;
      if (int'(a) > max_addr) max_addr = int'(a);
      if (phs) begin
        got.push_back(o);
        hs_cyc.push_back(cyc);
        waited = 0;
      end
      if (d) begin
        done_cyc.push_back(cyc);
        cnt_at_done = int'(cnt);
      end
      if (!b) begin
        end_cyc = cyc;
        break;
      end
      tick;
      cyc++;
    end
    abort = 0; start = 0; char_ready = 0; repeat_en = 0;
    chk("finished_in_budget", end_cyc >= 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    string msg = "ASSIGNMENT";
    for (int i = 0; i < 10; i++) rom[i] = msg[i];
    rom[10] = 8'h00;
    for (int i = 11; i < 16; i++) rom[i] = 8'h50 + 8'(i);
    rst = 1;
    tick; tick;
    rst = 0;
    chk("rst_addr", a10, 0);
    chk("rst_out", o10, 0);
    chk("rst_valid", v10, 0);
    chk("rst_busy", b10, 0);
    chk("rst_done", d10, 0);
    chk("rst_count", c10, 0);

    sel = 0;
    run(0, 0, -1, -1, 200);
    build(10, 10);
    cmp_stream("basic");
    for (int k = 0; k < hs_cyc.size(); k++) chk("basic_hs_cycle", hs_cyc[k], 2 + 2 * k);
    chk("basic_done_cnt", done_cyc.size(), 1);
    chk("basic_done_cycle", first_done(0), 21);
    chk("basic_count", cnt_at_done, 10);
    chk("basic_idle_cycle", end_cyc, 22);
    repeat (3) tick;

    run(1, 0, -1, -1, 200);
    cmp_stream("bp");
    chk("bp_done_cycle", first_done(0), 51);
    chk("bp_idle_cycle", end_cyc, 52);
    repeat (3) tick;

    sel = 1;
    run(2, 0, -1, -1, 400);
    build(16, 16);
    cmp_stream("nul");
    chk("nul_done_cnt", done_cyc.size(), 1);
    chk("nul_max_addr", max_addr, 10);
    chk("nul_idle_after_done", end_cyc, first_done(0) + 1);
    sel = 0;
    repeat (3) tick;

    run(0, 1000, 25, -1, 200);
    build(10, 25);
    cmp_stream("rep25");
    chk("rep25_done_cnt", done_cyc.size(), 2);
    chk("rep25_done0", first_done(0), 21);
    chk("rep25_done1", first_done(1), 41);
    chk("rep25_count", cnt, 5);
    chk("rep25_idle_cycle", end_cyc, 52);
    repeat (3) tick;

    run(2, 15, -1, -1, 400);
    build(10, 20);
    cmp_stream("repdrop");
    chk("repdrop_done_cnt", done_cyc.size(), 2);
    chk("repdrop_count", cnt_at_done, 10);
    repeat (3) tick;

    char_ready = 1;
    start = 1;
    tick;
    start = 0;
    repeat (7) tick;
    chk("abort_pre_valid", v10, 1);
    chk("abort_pre_count", c10, 3);
    char_ready = 0;
    abort = 1;
    tick;
    abort = 0;
    chk("abort_valid", v10, 0);
    chk("abort_done", d10, 0);
    chk("abort_count", c10, 3);
    chk("abort_busy", b10, 0);
    tick;
    chk("abort_no_late_done", d10, 0);
    repeat (2) tick;

    char_ready = 1;
    start = 1;
    tick;
    start = 0;
    repeat (7) tick;
    chk("rstmid_pre_valid", v10, 1);
    char_ready = 0;
    rst = 1;
    tick;
    rst = 0;
    chk("rstmid_addr", a10, 0);
    chk("rstmid_out", o10, 0);
    chk("rstmid_valid", v10, 0);
    chk("rstmid_busy", b10, 0);
    chk("rstmid_done", d10, 0);
    chk("rstmid_count", c10, 0);
    repeat (2) tick;

    run(0, 0, -1, 4, 200);
    build(10, 10);
    cmp_stream("startbusy");
    chk("startbusy_done_cycle", first_done(0), 21);
    chk("startbusy_count", cnt_at_done, 10);
    chk("startbusy_idle_cycle", end_cyc, 22);
    repeat (3) tick;

    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 10; i++) rom[i] = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 1) == 1) rom[$urandom_range(1, 9)] = 8'h00;
      run(2, 0, -1, -1, 400);
      build(10, 10);
      cmp_stream("rand");
      chk("rand_done_cnt", done_cyc.size(), 1);
      chk("rand_idle_after_done", end_cyc, first_done(0) + 1);
      repeat (3) tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
